// File: rtl/fp_dec_pkg.sv
// fp_dec_bcd shared definitions.
// Widths and FSM encoding for the BCD stage.
package fp_dec_pkg;

  localparam int W_IN   = 20;
  localparam int N_FRAC = 7;
  localparam int N_INT  = 2;
  localparam int N_EXP  = 3;
  localparam int BCD_W  = 4;
  localparam int W_NG   = 5;
  localparam int W_LT   = 9;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_DONE
  } state_t;

endpackage

// File: rtl/fp_dec_bcd_if.sv
// Handshake bundle between FPchange,
// the BCD stage and the formatter.
interface fp_dec_bcd_if;
  import fp_dec_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic [W_NG-1:0]           nguyen;
  logic [W_IN-1:0]           le;
  logic [W_LT-1:0]           lt;
  logic                      out_valid;
  logic                      out_ready;
  logic [BCD_W*N_INT-1:0]    int_bcd;
  logic [BCD_W*N_FRAC-1:0]   frac_bcd;
  logic                      exp_sign;
  logic [BCD_W*N_EXP-1:0]    exp_bcd;

  modport master (
    output in_valid,
    output nguyen,
    output le,
    output lt,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  int_bcd,
    input  frac_bcd,
    input  exp_sign,
    input  exp_bcd
  );

  modport slave (
    input  in_valid,
    input  nguyen,
    input  le,
    input  lt,
    input  out_ready,
    output in_ready,
    output out_valid,
    output int_bcd,
    output frac_bcd,
    output exp_sign,
    output exp_bcd
  );

endinterface

// File: rtl/dd_step.sv
// One double-dabble iteration:
// add 3 to nibbles >= 5, then shift left.
module dd_step
  import fp_dec_pkg::*;
#(
  parameter int N_DIG = 2
) (
  input  logic [BCD_W*N_DIG-1:0] bcd_i,
  input  logic [W_IN-1:0]        bin_i,
  output logic [BCD_W*N_DIG-1:0] bcd_o,
  output logic [W_IN-1:0]        bin_o
);

  logic [BCD_W*N_DIG-1:0] adj;

  // nibble correction before the shift
  always_comb begin
    adj = bcd_i;
    for (int d = 0; d < N_DIG; d++) begin
      if (bcd_i[d*BCD_W +: BCD_W] >= 4'd5) begin
        adj[d*BCD_W +: BCD_W] =
          bcd_i[d*BCD_W +: BCD_W] + 4'd3;
      end
    end
  end

  assign {bcd_o, bin_o} = {adj, bin_i} << 1;

endmodule

// File: rtl/fp_dec_bcd.sv
// BCD stage: integer, fraction and exponent
// to packed BCD, one shift per clock.
module fp_dec_bcd
  import fp_dec_pkg::*;
(
  input  logic         CLK,
  input  logic         RST,
  fp_dec_bcd_if.slave  io,
  output logic         busy
);

  localparam int WI = BCD_W*N_INT;
  localparam int WF = BCD_W*N_FRAC;
  localparam int WE = BCD_W*N_EXP;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [W_IN-1:0]  sh_int;
  logic [W_IN-1:0]  sh_frac;
  logic [W_IN-1:0]  sh_exp;
  logic [WI-1:0]    bcd_int;
  logic [WF-1:0]    bcd_frac;
  logic [WE-1:0]    bcd_exp;
  logic             sign_q;
  logic             ov_q;

  logic [WI-1:0]    nx_bint;
  logic [WF-1:0]    nx_bfrac;
  logic [WE-1:0]    nx_bexp;
  logic [W_IN-1:0]  nx_sint;
  logic [W_IN-1:0]  nx_sfrac;
  logic [W_IN-1:0]  nx_sexp;

  logic [W_LT:0]    lt_ext;
  logic [W_LT:0]    lt_abs;

  // 10-bit magnitude so -256 maps to 256
  assign lt_ext = {io.lt[W_LT-1], io.lt};
  assign lt_abs = io.lt[W_LT-1] ? -lt_ext
                                : lt_ext;

  assign io.in_ready  = (state == ST_IDLE);
  assign io.out_valid = ov_q;
  assign io.int_bcd   = bcd_int;
  assign io.frac_bcd  = bcd_frac;
  assign io.exp_bcd   = bcd_exp;
  assign io.exp_sign  = sign_q;

  dd_step #(.N_DIG(N_INT)) u_int (
    .bcd_i (bcd_int),
    .bin_i (sh_int),
    .bcd_o (nx_bint),
    .bin_o (nx_sint)
  );

  dd_step #(.N_DIG(N_FRAC)) u_frac (
    .bcd_i (bcd_frac),
    .bin_i (sh_frac),
    .bcd_o (nx_bfrac),
    .bin_o (nx_sfrac)
  );

  dd_step #(.N_DIG(N_EXP)) u_exp (
    .bcd_i (bcd_exp),
    .bin_i (sh_exp),
    .bcd_o (nx_bexp),
    .bin_o (nx_sexp)
  );

  // accept, convert for W_IN steps, hand off
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      sh_int   <= '0;
      sh_frac  <= '0;
      sh_exp   <= '0;
      bcd_int  <= '0;
      bcd_frac <= '0;
      bcd_exp  <= '0;
      sign_q   <= 1'b0;
      ov_q     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (io.in_valid) begin
            sh_int   <= W_IN'(io.nguyen);
            sh_frac  <= io.le;
            sh_exp   <= W_IN'(lt_abs);
            sign_q   <= io.lt[W_LT-1];
            bcd_int  <= '0;
            bcd_frac <= '0;
            bcd_exp  <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= ST_CONV;
          end
        end
        ST_CONV: begin
          sh_int   <= nx_sint;
          sh_frac  <= nx_sfrac;
          sh_exp   <= nx_sexp;
          bcd_int  <= nx_bint;
          bcd_frac <= nx_bfrac;
          bcd_exp  <= nx_bexp;
          cnt      <= cnt + 1'b1;
          if (cnt == CNT_W'(W_IN-1)) begin
            busy  <= 1'b0;
            ov_q  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (io.out_ready) begin
            ov_q  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_dec_bcd.sv
// Randomized bench for fp_dec_bcd with a
// decimal-arithmetic reference model.
module tb_fp_dec_bcd;

  typedef struct {
    logic [7:0]  ib;
    logic [27:0] fb;
    logic        sg;
    logic [11:0] eb;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  int n_chk = 0;
  int n_fail = 0;
  int n_done = 0;
  int cyc = 0;
  bit rnd_done = 0;
  bit prev_ov = 0;
  bit prev_hs = 0;

  logic [7:0]  got_i;
  logic [27:0] got_f;
  logic        got_s;
  logic [11:0] got_e;

  exp_t q[$];

  fp_dec_bcd_if bus ();

  fp_dec_bcd dut (
    .CLK  (clk),
    .RST  (rst_n),
    .io   (bus.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, got, exp);
    end
  endtask

  function automatic logic [31:0] to_bcd(
      input int v, input int n);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < n; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic exp_t model(
      input logic [4:0] ng,
      input logic [19:0] fr,
      input logic [8:0] lt,
      input int acc);
    exp_t e;
    int l;
    l = int'($signed(lt));
    if (l < 0) l = -l;
    e.ib  = 8'(to_bcd(int'(ng), 2));
    e.fb  = 28'(to_bcd(int'(fr), 7));
    e.sg  = lt[8];
    e.eb  = 12'(to_bcd(l, 3));
    e.acc = acc;
    return e;
  endfunction

  function automatic bit digits_ok();
    logic [47:0] all;
    all = {bus.int_bcd, bus.frac_bcd,
           bus.exp_bcd};
    for (int i = 0; i < 12; i++)
      if (all[4*i +: 4] > 4'd9) return 0;
    return 1;
  endfunction

  // compare process, sampled on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      prev_ov = 0;
      prev_hs = 0;
      chk("rst_out_valid", 64'(bus.out_valid), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_in_ready", 64'(bus.in_ready), 1);
      chk("rst_int", 64'(bus.int_bcd), 0);
      chk("rst_frac", 64'(bus.frac_bcd), 0);
      chk("rst_exp", 64'(bus.exp_bcd), 0);
      chk("rst_sign", 64'(bus.exp_sign), 0);
    end else begin
      if (prev_hs)
        chk("ready_after_hs",
            64'(bus.in_ready), 1);
      if (!bus.out_valid && !bus.in_ready)
        chk("busy_conv", 64'(busy), 1);
      if (bus.out_valid) begin
        chk("done_in_ready", 64'(bus.in_ready), 0);
        chk("done_busy", 64'(busy), 0);
        chk("digits", 64'(digits_ok()), 1);
        if (q.size() == 0) begin
          chk("spurious_valid", 64'(bus.out_valid), 0);
        end else begin
          if (!prev_ov)
            chk("latency", 64'(cyc - q[0].acc), 21);
          chk("int_bcd", 64'(bus.int_bcd), 64'(q[0].ib));
          chk("frac_bcd", 64'(bus.frac_bcd), 64'(q[0].fb));
          chk("exp_sign", 64'(bus.exp_sign), 64'(q[0].sg));
          chk("exp_bcd", 64'(bus.exp_bcd), 64'(q[0].eb));
          if (bus.out_ready) begin
            got_i = bus.int_bcd;
            got_f = bus.frac_bcd;
            got_s = bus.exp_sign;
            got_e = bus.exp_bcd;
            void'(q.pop_front());
            n_done++;
          end
        end
      end
      prev_hs = bus.out_valid && bus.out_ready;
      prev_ov = bus.out_valid && !bus.out_ready;
      if (bus.in_valid && bus.in_ready)
        q.push_back(model(bus.nguyen, bus.le,
                          bus.lt, cyc));
    end
  end

  // caller sits just after a rising edge
  task automatic send(input logic [4:0] ng,
                      input logic [19:0] fr,
                      input logic [8:0] lt);
    int k;
    bus.nguyen   = ng;
    bus.le       = fr;
    bus.lt       = lt;
    bus.in_valid = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.in_ready && k < 300);
    if (!bus.in_ready)
      chk("send_timeout", 64'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (n_done < target && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (n_done < target)
      chk("done_timeout", 64'(n_done), 64'(target));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int k;
    bus.in_valid  = 1'b0;
    bus.nguyen    = '0;
    bus.le        = '0;
    bus.lt        = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    bus.out_ready = 1'b1;
    base = n_done;
    send(5'd0, 20'd123456, 9'd0);
    wait_done(base + 1);
    chk("t1_int", 64'(got_i), 64'h00);
    chk("t1_frac", 64'(got_f), 64'h0123456);
    chk("t1_sign", 64'(got_s), 0);
    chk("t1_exp", 64'(got_e), 64'h000);

    base = n_done;
    send(5'd31, 20'hFFFFF, 9'h1DA);
    wait_done(base + 1);
    chk("t2_int", 64'(got_i), 64'h31);
    chk("t2_frac", 64'(got_f), 64'h1048575);
    chk("t2_sign", 64'(got_s), 1);
    chk("t2_exp", 64'(got_e), 64'h038);

    base = n_done;
    send(5'd1, 20'd0, 9'h100);
    wait_done(base + 1);
    chk("t3a_sign", 64'(got_s), 1);
    chk("t3a_exp", 64'(got_e), 64'h256);
    base = n_done;
    send(5'd9, 20'd10, 9'h0FF);
    wait_done(base + 1);
    chk("t3b_sign", 64'(got_s), 0);
    chk("t3b_exp", 64'(got_e), 64'h255);

    bus.out_ready = 1'b0;
    base = n_done;
    send(5'd3, 20'd42, 9'd7);
    k = 0;
    while (!bus.out_valid && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    for (int i = 0; i < 50; i++) begin
      bus.in_valid = i[0];
      bus.nguyen   = 5'($urandom);
      bus.le       = 20'($urandom);
      bus.lt       = 9'($urandom);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    chk("hold_valid", 64'(bus.out_valid), 1);
    chk("hold_count", 64'(n_done), 64'(base));
    bus.out_ready = 1'b1;
    wait_done(base + 1);
    chk("t4_int", 64'(got_i), 64'h03);
    chk("t4_frac", 64'(got_f), 64'h0000042);
    chk("t4_exp", 64'(got_e), 64'h007);

    base = n_done;
    send(5'd2, 20'd999, 9'd5);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(5'd0, 20'd7, 9'd0);
    wait_done(base + 1);
    chk("t5_frac", 64'(got_f), 64'h0000007);
    chk("t5_count", 64'(n_done), 64'(base + 1));

    base = n_done;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          send(5'($urandom), 20'($urandom),
               (i == 0) ? 9'h100 : 9'($urandom));
        end
        wait_done(base + 100);
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready = 1'b1;
    chk("rnd_count", 64'(n_done), 64'(base + 100));

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_dec_bcd.md
Name: fp_dec_bcd

Overview:
- Downstream stage of the float-to-decimal converter (FPchange).
- Captures its three results once per conversion: nguyen (integer part), le (fraction digits as binary) and lt (signed decimal exponent).
- Converts each to packed BCD with a sequential double-dabble engine, one shift per clock.
- Delivers the digits over a valid/ready handshake to the display/ASCII formatter.

Parameters:
- W_IN, 20, common shift length; every operand is zero-extended to this width.
- N_FRAC, 7, BCD digits for le (2^20-1 = 1048575 needs 7).
- N_INT, 2, BCD digits for nguyen (max 31).
- N_EXP, 3, BCD digits for |lt| (max 256).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-low reset.
- in_valid  input  1  nguyen/le/lt valid from the upstream converter.
- in_ready  output  1  high only in IDLE.
- nguyen  input  5  unsigned integer part.
- le  input  20  unsigned fraction value.
- lt  input  9  two's-complement decimal exponent.
- out_valid  output  1  result available; held until accepted.
- out_ready  input  1  downstream accepts the result.
- int_bcd  output  8  2 BCD digits, MSD in [7:4].
- frac_bcd  output  28  7 BCD digits, MSD in [27:24].
- exp_sign  output  1  1 when lt is negative.
- exp_bcd  output  12  3 BCD digits of |lt|.
- busy  output  1  high in CONV.

Behaviour:
- Reset (RST low, async): state=IDLE, count=0, all BCD/shift registers 0, exp_sign=0, out_valid=0, busy=0.
- in_ready is combinational: in_ready = (state==IDLE).
- FSM has 3 states.
- IDLE:
  - On an edge with in_valid=1, the transfer is accepted.
  - Latch zero-extended nguyen, le and |lt| into three W_IN-bit shift registers.
  - exp_sign <= lt[8]. |lt| is computed on 10 bits, so lt=9'h100 gives 256.
  - Clear the BCD accumulators, count <= 0, go to CONV.
- CONV, one double-dabble step per cycle on all three operands in parallel:
  - Every BCD nibble >= 5 gets +3.
  - Then {bcd,bin} shifts left by 1.
  - count increments.
  - When count reaches W_IN-1 and that step completes (20 steps total), go to DONE.
- DONE:
  - out_valid=1; int_bcd/frac_bcd/exp_bcd/exp_sign are stable.
  - On an edge with out_ready=1, go to IDLE and drop out_valid.
  - With out_ready=0, hold indefinitely.
- Latency: accept edge at cycle 0; out_valid is high after edge 20, i.e. 21 cycles from accept to first possible handoff.
- Throughput: one conversion per 22 cycles minimum. in_ready is low in DONE, so back-to-back inputs are accepted one cycle after out handoff.
- in_valid in CONV or DONE is ignored. Upstream holds its data because in_ready=0.
- Output BCD values are only meaningful while out_valid=1. They may change during CONV.
- Overflow is impossible by sizing. A digit counts as "valid" only if it is 0-9; the bench asserts this on every digit when out_valid=1.
- Reset mid-CONV or mid-DONE aborts immediately to the reset state. No partial result is ever flagged valid.
- Simultaneous out_ready and in_valid in DONE: only the output handshake completes that edge.

Decomposition:
- Shared package fp_dec_pkg holds:
  - width constants W_IN, N_FRAC, N_INT, N_EXP;
  - state encoding ST_IDLE/ST_CONV/ST_DONE;
  - BCD digit width 4.
- One sub-module, dd_step (parameter N_DIG): combinational add-3-then-shift of {bcd[4*N_DIG-1:0], bin[W_IN-1:0]}.
- dd_step is instantiated three times. The top module holds the FSM, counter and registers.

Test Plan:
- nguyen=5'd0, le=20'd123456, lt=9'd0, hold out_ready=1 -> out_valid exactly 21 cycles after accept; int_bcd=8'h00, frac_bcd=28'h0123456, exp_sign=0, exp_bcd=12'h000.
- nguyen=5'd31, le=20'hFFFFF, lt=-9'd38 (9'h1DA) -> int_bcd=8'h31, frac_bcd=28'h1048575, exp_sign=1, exp_bcd=12'h038.
- lt=9'h100, lt=9'h0FF -> exp_sign=1, exp_bcd=12'h256; exp_sign=0, exp_bcd=12'h255.
- out_ready held 0 for 50 cycles after DONE -> out_valid and data stable, in_ready=0, in_valid pulses ignored. Raising out_ready gives in_ready=1 on the next cycle.
- RST low at CONV count=10, then release, then new input le=20'd7 -> no out_valid from the aborted job; frac_bcd=28'h0000007 after 21 cycles.
- 100 random back-to-back vectors with random out_ready -> every result matches the reference model, and all digits are 0-9.
